// File: rtl/controlador_memoria_principal_pkg.sv
// Shared types and default sizing for the main-memory controller.
// The write-buffer entry type uses the default widths below.
package controlador_memoria_principal_pkg;

  localparam int ADDR_W_DEF   = 6;
  localparam int DATA_W_DEF   = 16;
  localparam int LAT_DEF      = 2;
  localparam int WB_DEPTH_DEF = 4;
  localparam int REQ_ADDR_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    RD_RAM,
    RESP,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/controlador_memoria_principal_ram.sv
// Single-port synchronous RAM with a registered read port and a write enable.
// Contents are never cleared, so they survive controller resets.
module memoria_ram_sinc #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              wren,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the storage array has no reset; clearing it would turn it into flops and break RAM inference.
  always_ff @(posedge clock) begin
    if (wren) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/controlador_memoria_principal.sv
// Main-memory controller: valid/ready request port, posted FIFO write buffer
// with youngest-match read forwarding, and a fixed-latency RAM sequencer.
module controlador_memoria_principal
  import controlador_memoria_principal_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LAT      = LAT_DEF,
  parameter int WB_DEPTH = WB_DEPTH_DEF,
  localparam int CNT_W   = $clog2(WB_DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [REQ_ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  busy,
  output logic [CNT_W-1:0]      wb_count
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int LAT_W = $clog2(LAT + 1);

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  wb_entry_t          wb_mem [WB_DEPTH];
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q;
  logic               push, pop;

  logic               accept;
  logic [ADDR_W-1:0]  req_word;
  logic               fwd_hit;
  logic [DATA_W-1:0]  fwd_data;

  logic               ram_wren;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_wdata;
  logic [DATA_W-1:0]  ram_rdata;

  assign req_word  = req_addr[ADDR_W-1:0];
  assign req_ready = (state_q == IDLE) && (count_q < CNT_W'(WB_DEPTH)) && !reset;
  assign accept    = req_valid && req_ready;

  // Walk entries oldest to youngest so the last match seen is the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && (wb_mem[head_q + PTR_W'(i)].addr == req_word)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_mem[head_q + PTR_W'(i)].data;
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    rd_addr_d  = rd_addr_q;
    rdata_d    = rdata_q;
    push       = 1'b0;
    pop        = 1'b0;
    ram_wren   = 1'b0;
    ram_addr   = rd_addr_q;
    ram_wdata  = wb_mem[head_q].data;
    resp_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        ram_addr = req_word;
        if (accept) begin
          if (req_write) begin
            push = 1'b1;
          end else if (fwd_hit) begin
            rdata_d = fwd_data;
            state_d = RESP;
          end else begin
            rd_addr_d = req_word;
            lat_cnt_d = LAT_W'(LAT);
            state_d   = RD_RAM;
          end
        end else if (count_q != '0) begin
          lat_cnt_d = LAT_W'(LAT);
          state_d   = DRAIN;
        end
      end

      RD_RAM: begin
        lat_cnt_d = lat_cnt_q - LAT_W'(1);
        if (lat_cnt_q == LAT_W'(1)) begin
          rdata_d = ram_rdata;
          state_d = RESP;
        end
      end

      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end

      DRAIN: begin
        ram_addr  = wb_mem[head_q].addr;
        lat_cnt_d = lat_cnt_q - LAT_W'(1);
        // The RAM write lands on the final cycle, together with the pop.
        if (lat_cnt_q == LAT_W'(1)) begin
          ram_wren = 1'b1;
          pop      = 1'b1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      rd_addr_q <= '0;
      rdata_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      rd_addr_q <= rd_addr_d;
      rdata_q   <= rdata_d;
      if (push) begin
        tail_q  <= tail_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(1);
      end
      if (pop) begin
        head_q  <= head_q + PTR_W'(1);
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Entry payloads need no reset: only slots covered by count_q are ever read as valid.
  always_ff @(posedge clock) begin
    if (push) wb_mem[tail_q] <= '{addr: req_word, data: req_wdata};
  end

  memoria_ram_sinc #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clock (clock),
    .wren  (ram_wren),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign resp_rdata = rdata_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign wb_count   = count_q;

endmodule
